// File: rtl/hdmi_period_scheduler_if.sv
// Bundle of signals between the HDMI period scheduler and its consumers.
// The consumers are the packet source and the TMDS encoder front end.
//   packet_pending : packet source -> scheduler, a packet is ready to send
//   cx, cy         : raster position of the pixel being described
//   mode           : period type of that pixel (CTRL, video or island phases)
//   hsync, vsync   : active-high sync levels for that pixel
//   packet_start   : first I_DATA pixel of a packet slot
//   packet_index   : packet number within the current data island
//   slot_pos       : pixel offset 0..31 within the current packet slot
// The master modport is the scheduler. The slave modport is a consumer.
interface hdmi_period_scheduler_if #(
  parameter int CX_W = 10,
  parameter int CY_W = 10
);
  logic            packet_pending;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic [2:0]      mode;
  logic            hsync;
  logic            vsync;
  logic            packet_start;
  logic [4:0]      packet_index;
  logic [4:0]      slot_pos;

  modport master (
    input  packet_pending,
    output cx, cy, mode, hsync, vsync, packet_start, packet_index, slot_pos
  );

  modport slave (
    output packet_pending,
    input  cx, cy, mode, hsync, vsync, packet_start, packet_index, slot_pos
  );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer in the clk_pixel domain.
// It keeps the raster counters and labels each pixel with a period mode:
//   CTRL, video preamble/guard/data, or data island preamble/guard/data.
// It also hands out 32-pixel packet slots to the packet source.
// Every output is registered, and all outputs in a cycle describe the same pixel.
// Ports:
//   clk_pixel : pixel clock
//   reset     : asynchronous, active-high reset
//   bus       : hdmi_period_scheduler_if.master
//               packet_pending is the input; all other signals are outputs.
module hdmi_period_scheduler #(
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int HSYNC_START   = 656,
  parameter int HSYNC_SIZE    = 96,
  parameter int VSYNC_START   = 490,
  parameter int VSYNC_SIZE    = 2,
  parameter int MAX_PACKETS   = 18
) (
  input logic                    clk_pixel,
  input logic                    reset,
  hdmi_period_scheduler_if.master bus
);
  localparam int W = $clog2(FRAME_WIDTH);
  localparam int H = $clog2(FRAME_HEIGHT);

  localparam logic [2:0] M_CTRL    = 3'd0;
  localparam logic [2:0] M_V_PRE   = 3'd1;
  localparam logic [2:0] M_V_GUARD = 3'd2;
  localparam logic [2:0] M_V_DATA  = 3'd3;
  localparam logic [2:0] M_I_PRE   = 3'd4;
  localparam logic [2:0] M_I_GUARD = 3'd5;
  localparam logic [2:0] M_I_DATA  = 3'd6;

  // Sync levels decoded for the reset position (SCREEN_WIDTH, FRAME_HEIGHT-1).
  localparam logic HSYNC_RST = (SCREEN_WIDTH >= HSYNC_START) &&
                               (SCREEN_WIDTH < HSYNC_START + HSYNC_SIZE);
  localparam logic VSYNC_RST = (FRAME_HEIGHT - 1 >= VSYNC_START) &&
                               (FRAME_HEIGHT - 1 < VSYNC_START + VSYNC_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGUARD, S_DATA, S_TGUARD} isl_state_t;

  isl_state_t st, st_n;
  logic [2:0] cnt, cnt_n;          // pixel count within PRE / guard phases
  logic [3:0] ctrl_run, ctrl_run_n;
  logic [4:0] idx_n, spos_n;
  logic       pstart_n;
  logic [2:0] mode_n;
  logic       hsync_n, vsync_n;
  logic       nact_n;
  int         cx_i, cy_i, nx, ny, limit_n;

  // Position of the pixel that is presented after the next edge. All other
  // decisions are made against this position, so every output in a cycle
  // describes the same pixel.
  always_comb begin
    cx_i = int'(bus.cx);
    cy_i = int'(bus.cy);
    if (cx_i == FRAME_WIDTH - 1) begin
      nx = 0;
      ny = (cy_i == FRAME_HEIGHT - 1) ? 0 : cy_i + 1;
    end else begin
      nx = cx_i + 1;
      ny = cy_i;
    end
    // The line after ny is active. Such a line ends in the video preamble and
    // guard, so an island must be finished before FRAME_WIDTH-10.
    nact_n  = (((ny == FRAME_HEIGHT - 1) ? 0 : ny + 1) < SCREEN_HEIGHT);
    limit_n = nact_n ? FRAME_WIDTH - 10 : FRAME_WIDTH;
  end

  // Island FSM: state register
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      st  <= S_IDLE;
      cnt <= 3'd0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  // Island FSM: next state plus the slot and packet bookkeeping.
  // The numbers 48 and 38 reserve the full island tail and the 4-pixel CTRL
  // gap before the limit. 48 = 8 PRE + 2 guard + 32 data + 2 guard + 4 CTRL.
  // 38 = 32 data + 2 guard + 4 CTRL.
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    idx_n    = bus.packet_index;
    spos_n   = bus.slot_pos;
    pstart_n = 1'b0;
    case (st)
      S_IDLE: begin
        if (bus.mode == M_CTRL && ctrl_run >= 4'd4 && bus.packet_pending &&
            (nx + 48 <= limit_n)) begin
          st_n  = S_PRE;
          cnt_n = 3'd0;
        end
      end
      S_PRE: begin
        if (cnt == 3'd7) begin
          st_n  = S_LGUARD;
          cnt_n = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      S_LGUARD: begin
        if (cnt == 3'd1) begin
          st_n     = S_DATA;
          spos_n   = 5'd0;
          pstart_n = 1'b1;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      S_DATA: begin
        if (bus.slot_pos == 5'd31) begin
          if (bus.packet_pending && (int'(bus.packet_index) + 1 < MAX_PACKETS) &&
              (nx + 38 <= limit_n)) begin
            spos_n   = 5'd0;
            idx_n    = bus.packet_index + 5'd1;
            pstart_n = 1'b1;
          end else begin
            st_n  = S_TGUARD;
            cnt_n = 3'd0;
          end
        end else begin
          spos_n = bus.slot_pos + 5'd1;
        end
      end
      S_TGUARD: begin
        if (cnt == 3'd1) begin
          st_n  = S_IDLE;
          idx_n = 5'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  // Island FSM: outputs. Video periods take priority over the island state.
  always_comb begin
    hsync_n = (nx >= HSYNC_START) && (nx < HSYNC_START + HSYNC_SIZE);
    vsync_n = (ny >= VSYNC_START) && (ny < VSYNC_START + VSYNC_SIZE);
    if (nx < SCREEN_WIDTH && ny < SCREEN_HEIGHT) begin
      mode_n = M_V_DATA;
    end else if (nact_n && nx >= FRAME_WIDTH - 10 && nx <= FRAME_WIDTH - 3) begin
      mode_n = M_V_PRE;
    end else if (nact_n && nx >= FRAME_WIDTH - 2) begin
      mode_n = M_V_GUARD;
    end else begin
      case (st_n)
        S_PRE:              mode_n = M_I_PRE;
        S_LGUARD, S_TGUARD: mode_n = M_I_GUARD;
        S_DATA:             mode_n = M_I_DATA;
        default:            mode_n = M_CTRL;
      endcase
    end
    if (mode_n == M_CTRL) begin
      ctrl_run_n = (ctrl_run == 4'd15) ? 4'd15 : ctrl_run + 4'd1;
    end else begin
      ctrl_run_n = 4'd0;
    end
  end

  // Output register stage
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      bus.cx           <= W'(SCREEN_WIDTH);
      bus.cy           <= H'(FRAME_HEIGHT - 1);
      bus.mode         <= M_CTRL;
      bus.hsync        <= HSYNC_RST;
      bus.vsync        <= VSYNC_RST;
      bus.packet_start <= 1'b0;
      bus.packet_index <= 5'd0;
      bus.slot_pos     <= 5'd0;
      ctrl_run         <= 4'd0;
    end else begin
      bus.cx           <= W'(nx);
      bus.cy           <= H'(ny);
      bus.mode         <= mode_n;
      bus.hsync        <= hsync_n;
      bus.vsync        <= vsync_n;
      bus.packet_start <= pstart_n;
      bus.packet_index <= idx_n;
      bus.slot_pos     <= spos_n;
      ctrl_run         <= ctrl_run_n;
    end
  end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler using the small test raster.
// The raster is 160x6 with 40x4 active pixels and MAX_PACKETS=2.
// The stimulus task pushes the hand-derived expectation for each pixel.
// A negedge monitor pops each expectation and compares it with the interface.
module tb_hdmi_period_scheduler;
  localparam int FW  = 160;
  localparam int FH  = 6;
  localparam int SW  = 40;
  localparam int SH  = 4;
  localparam int HS  = 45;
  localparam int HZ  = 5;
  localparam int VS  = 4;
  localparam int VZ  = 1;
  localparam int MP  = 2;
  localparam int CXW = $clog2(FW);
  localparam int CYW = $clog2(FH);

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;

  hdmi_period_scheduler_if #(.CX_W(CXW), .CY_W(CYW)) bus ();

  hdmi_period_scheduler #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
    .HSYNC_START(HS), .HSYNC_SIZE(HZ), .VSYNC_START(VS), .VSYNC_SIZE(VZ),
    .MAX_PACKETS(MP)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [2:0]     mode;
    logic           hs;
    logic           vs;
    logic           ps;
    logic [4:0]     pidx;
    logic [4:0]     spos;
  } pix_t;

  pix_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ecx    = SW;
  int   ecy    = FH - 1;
  int   h_spos = 0;
  int   h_pidx = 0;

  // Island layout per line for each scenario, as {start cx, packet count}.
  // A start of -1 means no island.
  task automatic get_desc(input int ph, input int cy,
                          output int s0, output int n0, output int s1, output int n1);
    s0 = -1; n0 = 0; s1 = -1; n1 = 0;
    case (ph)
      1: begin
        if (cy <= 3) begin s0 = 44; n0 = 2; end
        else if (cy == 4) begin s0 = 0; n0 = 2; s1 = 80; n1 = 2; end
        else begin s0 = 0; n0 = 2; s1 = 80; n1 = 1; end
      end
      2: if (cy == 0) begin s0 = 44; n0 = 1; end
      3: if (cy == 1) begin s0 = 44; n0 = 2; end
      4: begin
        if (cy == 5) begin s0 = 45; n0 = 2; end
        else if (cy == 0) begin s0 = 44; n0 = 2; end
      end
      default: ;
    endcase
  endtask

  // One pixel clock. pm selects pending: 0 low, 1 high, 2 high only while cx=43 on cy=0.
  task automatic cyc(input int pm, input logic rst_v, input int ph);
    int   s0, n0, s1, n1, m, rel;
    int   ss[2];
    int   nn[2];
    logic ps, trail, nact, pend;
    pix_t e;
    @(posedge clk_pixel);
    if (!reset) begin
      if (ecx == FW - 1) begin
        ecx = 0;
        ecy = (ecy == FH - 1) ? 0 : ecy + 1;
      end else begin
        ecx = ecx + 1;
      end
    end
    #2;
    pend = (pm == 1) || (pm == 2 && ecx == 43 && ecy == 0);
    reset = rst_v;
    bus.packet_pending = pend;
    if (rst_v) begin
      ecx = SW; ecy = FH - 1; h_spos = 0; h_pidx = 0;
    end
    get_desc(ph, ecy, s0, n0, s1, n1);
    ss[0] = s0; nn[0] = n0; ss[1] = s1; nn[1] = n1;
    m = 0; ps = 1'b0; trail = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (ss[k] >= 0) begin
        rel = ecx - ss[k];
        if (rel >= 0 && rel < 12 + 32 * nn[k]) begin
          if (rel < 8) m = 4;
          else if (rel < 10) m = 5;
          else if (rel < 10 + 32 * nn[k]) begin
            m = 6;
            h_pidx = (rel - 10) / 32;
            h_spos = (rel - 10) % 32;
            ps = (h_spos == 0);
          end else begin
            m = 5;
            trail = 1'b1;
          end
        end
      end
    end
    nact = (((ecy + 1) % FH) < SH);
    if (ecx < SW && ecy < SH) m = 3;
    else if (nact && ecx >= FW - 10 && ecx <= FW - 3) m = 1;
    else if (nact && ecx >= FW - 2) m = 2;
    if (m != 6 && !trail) h_pidx = 0;
    if (rst_v) begin m = 0; ps = 1'b0; end
    e.cx   = CXW'(ecx);
    e.cy   = CYW'(ecy);
    e.mode = 3'(m);
    e.hs   = (ecx >= HS && ecx < HS + HZ);
    e.vs   = (ecy >= VS && ecy < VS + VZ);
    e.ps   = ps;
    e.pidx = 5'(h_pidx);
    e.spos = 5'(h_spos);
    sb.push_back(e);
  endtask

  // Monitor: one comparison per presented pixel.
  always @(negedge clk_pixel) begin
    pix_t ex, ac;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      ac.cx   = bus.cx;
      ac.cy   = bus.cy;
      ac.mode = bus.mode;
      ac.hs   = bus.hsync;
      ac.vs   = bus.vsync;
      ac.ps   = bus.packet_start;
      ac.pidx = bus.packet_index;
      ac.spos = bus.slot_pos;
      n_chk++;
      if (ac === ex) n_pass++;
      else $display("FAIL pixel got cx=%0d cy=%0d mode=%0d hs=%0b vs=%0b ps=%0b idx=%0d pos=%0d, want cx=%0d cy=%0d mode=%0d hs=%0b vs=%0b ps=%0b idx=%0d pos=%0d",
                    ac.cx, ac.cy, ac.mode, ac.hs, ac.vs, ac.ps, ac.pidx, ac.spos,
                    ex.cx, ex.cy, ex.mode, ex.hs, ex.vs, ex.ps, ex.pidx, ex.spos);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.packet_pending = 1'b0;
    // Reset, then two idle frames: raster wraps, video periods, sync decode.
    repeat (3) cyc(0, 1'b1, 0);
    repeat (FW * FH * 2) cyc(0, 1'b0, 0);
    while (!(ecx == FW - 1 && ecy == FH - 1)) cyc(0, 1'b0, 0);
    // A frame with pending held high: two-packet islands, back-to-back islands, limits.
    do cyc(1, 1'b0, 1); while (!(ecx == FW - 1 && ecy == FH - 1));
    // Pending high only at the start decision: one packet, then trailing guard.
    do cyc(2, 1'b0, 2); while (!(ecx == FW - 1 && ecy == 0));
    // Island on cy=1, then an asynchronous reset at cx=60 in the middle of the island.
    do cyc(1, 1'b0, 3); while (!(ecx == 59 && ecy == 1));
    cyc(1, 1'b1, 3);
    cyc(1, 1'b1, 4);
    cyc(1, 1'b0, 4);
    do cyc(1, 1'b0, 4); while (!(ecx == FW - 1 && ecy == 0));
    repeat (20) cyc(0, 1'b0, 0);
    repeat (2) @(negedge clk_pixel);
    #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d left, want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
